// File: rtl/vrf_read_pipe_pkg.sv
// vrf_read_pipe_pkg: default widths for the VRF read pipe and a helper that sizes
// channel/pointer indices (never narrower than one bit).
package vrf_read_pipe_pkg;
    localparam int DefChannels = 2;
    localparam int DefDataW    = 32;
    localparam int DefDepth    = 4;
    localparam int DefVrfLat   = 2;
    localparam int DefVsW      = 5;
    localparam int DefOffsetW  = 2;
    localparam int DefSrcW     = 2;
    localparam int DefIdxW     = 3;

    function automatic int idxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vrf_read_data_fifo.sv
// vrf_read_data_fifo: per-channel circular result buffer; a push while full is
// only accepted when a pop frees the head slot in the same cycle.
module vrf_read_data_fifo
    import vrf_read_pipe_pkg::*;
#(
    parameter int DATA_W = DefDataW,
    parameter int DEPTH  = DefDepth
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] pushData,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] data
);
    localparam int PW = idxW(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [NW-1:0] count;
    logic doPush, doPop;

    assign empty  = count == '0;
    assign full   = count == NW'(DEPTH);
    assign data   = mem[rdPtr];
    assign doPop  = pop & !empty;
    assign doPush = push & (!full | doPop);

    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            if (doPush != doPop) count <= doPush ? count + 1'b1 : count - 1'b1;
        end
    end
endmodule

// File: rtl/vrf_read_pipe_mc.sv
// vrf_read_pipe_mc: round-robin arbitration of credit-limited channels onto one VRF
// read port, fixed-latency result tracking and per-channel result FIFOs.
// Define VRF_READ_PIPE_BYPASS_EN to present results to an empty FIFO's consumer directly.
module vrf_read_pipe_mc
    import vrf_read_pipe_pkg::*;
#(
    parameter int CHANNELS = DefChannels,
    parameter int DATA_W   = DefDataW,
    parameter int DEPTH    = DefDepth,
    parameter int VRF_LAT  = DefVrfLat,
    parameter int VS_W     = DefVsW,
    parameter int OFFSET_W = DefOffsetW,
    parameter int SRC_W    = DefSrcW,
    parameter int IDX_W    = DefIdxW
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          enqueue_valid,
    output logic [CHANNELS-1:0]          enqueue_ready,
    input  logic [CHANNELS*VS_W-1:0]     enqueue_vs,
    input  logic [CHANNELS*OFFSET_W-1:0] enqueue_offset,
    input  logic [CHANNELS*SRC_W-1:0]    enqueue_readSource,
    input  logic [CHANNELS*IDX_W-1:0]    enqueue_instructionIndex,
    output logic                         vrfReadRequest_valid,
    input  logic                         vrfReadRequest_ready,
    output logic [VS_W-1:0]              vrfReadRequest_bits_vs,
    output logic [OFFSET_W-1:0]          vrfReadRequest_bits_offset,
    output logic [SRC_W-1:0]             vrfReadRequest_bits_readSource,
    output logic [IDX_W-1:0]             vrfReadRequest_bits_instructionIndex,
    input  logic [DATA_W-1:0]            vrfReadResult,
    output logic [CHANNELS-1:0]          dequeue_valid,
    input  logic [CHANNELS-1:0]          dequeue_ready,
    output logic [CHANNELS*DATA_W-1:0]   dequeue_bits,
    output logic                         overflow_err
);
    localparam int CW = idxW(CHANNELS);
    localparam int NW = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0] eligible, grant, overflowHit;
    logic [CW-1:0] rrPtr, grantId, arriveChan;
    logic [CW-1:0] pipeChan [VRF_LAT];
    logic [VRF_LAT-1:0] pipeValid;
    logic fire, arrive;

    // Walk from the highest offset down so the lowest offset from rrPtr wins.
    always_comb begin
        grant = '0;
        grantId = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            automatic int idx = (int'(rrPtr) + k) % CHANNELS;
            if (eligible[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
                grantId = CW'(idx);
            end
        end
    end

    assign vrfReadRequest_valid = |eligible;
    assign enqueue_ready = grant & {CHANNELS{vrfReadRequest_ready}};
    assign fire = vrfReadRequest_valid & vrfReadRequest_ready;
    assign vrfReadRequest_bits_vs = enqueue_vs[int'(grantId)*VS_W +: VS_W];
    assign vrfReadRequest_bits_offset = enqueue_offset[int'(grantId)*OFFSET_W +: OFFSET_W];
    assign vrfReadRequest_bits_readSource = enqueue_readSource[int'(grantId)*SRC_W +: SRC_W];
    assign vrfReadRequest_bits_instructionIndex = enqueue_instructionIndex[int'(grantId)*IDX_W +: IDX_W];
    assign arrive = pipeValid[VRF_LAT-1];
    assign arriveChan = pipeChan[VRF_LAT-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr <= '0;
            pipeValid <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (fire) rrPtr <= (grantId == CW'(CHANNELS - 1)) ? '0 : grantId + 1'b1;
            pipeValid[0] <= fire;
            for (int k = 1; k < VRF_LAT; k++) pipeValid[k] <= pipeValid[k-1];
            if (|overflowHit) overflow_err <= 1'b1;
        end
        pipeChan[0] <= grantId;
        for (int k = 1; k < VRF_LAT; k++) pipeChan[k] <= pipeChan[k-1];
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : gChan
        logic hit, push, pop, empty, full, deqFire;
        logic [DATA_W-1:0] fifoData;
        logic [NW-1:0] cnt;

        assign eligible[c] = !reset & enqueue_valid[c] & (cnt < NW'(DEPTH));
        assign hit = arrive & !reset & (arriveChan == CW'(c));
`ifdef VRF_READ_PIPE_BYPASS_EN
        assign dequeue_valid[c] = !empty | hit;
        assign dequeue_bits[c*DATA_W +: DATA_W] = empty ? vrfReadResult : fifoData;
        assign push = hit & !(empty & dequeue_ready[c]);
`else
        assign dequeue_valid[c] = !empty;
        assign dequeue_bits[c*DATA_W +: DATA_W] = fifoData;
        assign push = hit;
`endif
        assign pop = dequeue_ready[c];
        assign deqFire = dequeue_valid[c] & dequeue_ready[c];
        assign overflowHit[c] = push & full & !(pop & !empty);

        always_ff @(posedge clock) begin
            if (reset) cnt <= '0;
            else if (enqueue_ready[c] != deqFire) cnt <= enqueue_ready[c] ? cnt + 1'b1 : cnt - 1'b1;
        end

        vrf_read_data_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) uFifo (
            .clock(clock),
            .reset(reset),
            .push(push),
            .pop(pop),
            .pushData(vrfReadResult),
            .empty(empty),
            .full(full),
            .data(fifoData)
        );
    end
endmodule

// File: tb/tb_vrf_read_pipe_mc.sv
// tb_vrf_read_pipe_mc: directed checks of arbitration, credits, latency, ordering
// and reset flushing for the default two-channel configuration.
module tb_vrf_read_pipe_mc;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] enqueue_valid = '0, enqueue_ready, dequeue_valid, dequeue_ready = '0;
    logic [9:0] enqueue_vs = {5'd7, 5'd3};
    logic [3:0] enqueue_offset = {2'd2, 2'd1};
    logic [3:0] enqueue_readSource = {2'd3, 2'd0};
    logic [5:0] enqueue_instructionIndex = {3'd5, 3'd2};
    logic vrfReadRequest_valid, vrfReadRequest_ready = 1'b0, overflow_err;
    logic [4:0] vrfReadRequest_bits_vs;
    logic [1:0] vrfReadRequest_bits_offset, vrfReadRequest_bits_readSource;
    logic [2:0] vrfReadRequest_bits_instructionIndex;
    logic [31:0] vrfReadResult = '0;
    logic [63:0] dequeue_bits;

    int total = 0;
    int passed = 0;

    always #5 clock = ~clock;

    vrf_read_pipe_mc dut (
        .clock(clock),
        .reset(reset),
        .enqueue_valid(enqueue_valid),
        .enqueue_ready(enqueue_ready),
        .enqueue_vs(enqueue_vs),
        .enqueue_offset(enqueue_offset),
        .enqueue_readSource(enqueue_readSource),
        .enqueue_instructionIndex(enqueue_instructionIndex),
        .vrfReadRequest_valid(vrfReadRequest_valid),
        .vrfReadRequest_ready(vrfReadRequest_ready),
        .vrfReadRequest_bits_vs(vrfReadRequest_bits_vs),
        .vrfReadRequest_bits_offset(vrfReadRequest_bits_offset),
        .vrfReadRequest_bits_readSource(vrfReadRequest_bits_readSource),
        .vrfReadRequest_bits_instructionIndex(vrfReadRequest_bits_instructionIndex),
        .vrfReadResult(vrfReadResult),
        .dequeue_valid(dequeue_valid),
        .dequeue_ready(dequeue_ready),
        .dequeue_bits(dequeue_bits),
        .overflow_err(overflow_err)
    );

    typedef struct {
        logic [1:0] ev;
        logic       rdy;
        logic [1:0] expReady;
        logic       expValid;
        int         expCh;
    } vec_t;

    vec_t vecs [12];
    logic [31:0] expData [9];
    logic expRdy [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        enqueue_valid = '0;
        dequeue_ready = '0;
        vrfReadRequest_ready = 1'b0;
        vrfReadResult = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [11:0] reqBits(input int ch);
        return (ch == 0) ? {5'd3, 2'd1, 2'd0, 3'd2} : {5'd7, 2'd2, 2'd3, 3'd5};
    endfunction

    function automatic logic [11:0] dutBits();
        return {vrfReadRequest_bits_vs, vrfReadRequest_bits_offset,
                vrfReadRequest_bits_readSource, vrfReadRequest_bits_instructionIndex};
    endfunction

    initial begin
        int fires;
        vecs[0]  = '{2'b11, 1'b1, 2'b01, 1'b1, 0};
        vecs[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1};
        vecs[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 0};
        vecs[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1};
        vecs[4]  = '{2'b10, 1'b0, 2'b00, 1'b1, 1};
        vecs[5]  = '{2'b10, 1'b0, 2'b00, 1'b1, 1};
        vecs[6]  = '{2'b10, 1'b0, 2'b00, 1'b1, 1};
        vecs[7]  = '{2'b11, 1'b1, 2'b01, 1'b1, 0};
        vecs[8]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1};
        vecs[9]  = '{2'b01, 1'b1, 2'b01, 1'b1, 0};
        vecs[10] = '{2'b01, 1'b1, 2'b01, 1'b1, 0};
        vecs[11] = '{2'b00, 1'b1, 2'b00, 1'b0, 0};
        expData = '{32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7};
        expRdy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset: requests presented while reset is high must not be visible.
        enqueue_valid = 2'b11;
        vrfReadRequest_ready = 1'b1;
        tick();
        tick();
        #2;
        check("reset_enq_ready", enqueue_ready, 2'b00);
        check("reset_req_valid", vrfReadRequest_valid, 1'b0);
        check("reset_deq_valid", dequeue_valid, 2'b00);
        check("reset_overflow", overflow_err, 1'b0);

        // Single read on channel 0.
        doReset();
        enqueue_valid = 2'b01;
        vrfReadRequest_ready = 1'b1;
        #2;
        check("single_enq_ready", enqueue_ready, 2'b01);
        check("single_req_bits", dutBits(), reqBits(0));
        tick();
        enqueue_valid = 2'b00;
        tick();
        vrfReadResult = 32'hDEADBEEF;
        #2;
`ifdef VRF_READ_PIPE_BYPASS_EN
        check("single_bypass_valid", dequeue_valid, 2'b01);
        check("single_bypass_bits", dequeue_bits[31:0], 32'hDEADBEEF);
`else
        check("single_early_valid", dequeue_valid, 2'b00);
`endif
        tick();
        vrfReadResult = '0;
        #2;
        check("single_deq_valid", dequeue_valid, 2'b01);
        check("single_deq_bits", dequeue_bits[31:0], 32'hDEADBEEF);
        dequeue_ready = 2'b01;
        tick();
        #2;
        check("single_drained", dequeue_valid, 2'b00);

        // Round-robin and port backpressure table.
        doReset();
        dequeue_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            enqueue_valid = vecs[i].ev;
            vrfReadRequest_ready = vecs[i].rdy;
            #2;
            check($sformatf("rr%0d_enq_ready", i), enqueue_ready, vecs[i].expReady);
            check($sformatf("rr%0d_req_valid", i), vrfReadRequest_valid, vecs[i].expValid);
            if (vecs[i].expValid) check($sformatf("rr%0d_req_bits", i), dutBits(), reqBits(vecs[i].expCh));
            tick();
        end
        enqueue_valid = '0;
        repeat (4) tick();
        #2;
        check("rr_drained", dequeue_valid, 2'b00);

        // Credit stall: four fires fill channel 0, then it is held off.
        doReset();
        enqueue_valid = 2'b01;
        vrfReadRequest_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            vrfReadResult = 32'hA0 + 32'(i);
            #2;
            if (enqueue_ready[0]) fires++;
            tick();
        end
        check("stall_fires", 64'(fires), 64'd4);
        dequeue_ready = 2'b01;
        #2;
        check("stall_no_comb_ready", enqueue_ready, 2'b00);
        for (int j = 0; j < 9; j++) begin
            vrfReadResult = 32'hC0 + 32'(j);
            enqueue_valid = (j <= 5) ? 2'b01 : 2'b00;
            #2;
            check($sformatf("stream%0d_deq_valid", j), dequeue_valid[0], 1'b1);
            check($sformatf("stream%0d_deq_bits", j), dequeue_bits[31:0], expData[j]);
            check($sformatf("stream%0d_enq_ready", j), enqueue_ready[0], expRdy[j]);
            check($sformatf("stream%0d_ch1_idle", j), dequeue_valid[1], 1'b0);
            tick();
        end
        #2;
        check("stream_empty", dequeue_valid, 2'b00);
        check("stream_overflow", overflow_err, 1'b0);

        // Reset one cycle after a fire flushes the in-flight read.
        dequeue_ready = 2'b00;
        enqueue_valid = 2'b01;
        #2;
        check("flush_fire", enqueue_ready, 2'b01);
        tick();
        enqueue_valid = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vrfReadResult = 32'hDEAD0001;
        #2;
        check("flush_arrival_cycle", dequeue_valid, 2'b00);
        tick();
        vrfReadResult = '0;
        #2;
        check("flush_after_arrival", dequeue_valid, 2'b00);
        tick();
        tick();
        #2;
        check("flush_later", dequeue_valid, 2'b00);
        enqueue_valid = 2'b01;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (enqueue_ready[0]) fires++;
            tick();
        end
        check("flush_credits_restored", 64'(fires), 64'd4);
        check("final_overflow", overflow_err, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
